// File: rtl/uart_rx_loader.sv
// Serial byte receiver that stores each good frame into memory at an auto-incrementing
// address and flags done after LOAD_BYTES bytes. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 8,
   parameter int LOAD_BYTES   = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rx,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic              parity_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(LOAD_BYTES - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic                sync1_q, rxs_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                armed_q, armed_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                done_q, done_d;
   logic                wr_q, wr_d;
   logic [7:0]          data_q, data_d;
   logic                ferr_q, ferr_d;
   logic                par_bad;
`ifdef UART_RX_PARITY_EN
   logic                par_bad_q, par_bad_d;
   logic                perr_q, perr_d;
   assign par_bad = par_bad_q;
`else
   assign par_bad = 1'b0;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rx;
         rxs_q   <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      armed_d = armed_q;
      ptr_d   = ptr_q;
      done_d  = done_q;
      wr_d    = 1'b0;
      data_d  = data_q;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      // The pointer advances on the edge after a write unless that write was the last one.
      if (wr_q && !done_q) begin
         ptr_d = ptr_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rxs_q) begin
               armed_d = 1'b1;
            end
            if (armed_q && !rxs_q && !done_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rxs_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               par_bad_d = rxs_q ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               armed_d = 1'b0;
               ferr_d  = !rxs_q;
`ifdef UART_RX_PARITY_EN
               perr_d  = par_bad_q;
`endif
               if (rxs_q && !par_bad && !done_q) begin
                  wr_d   = 1'b1;
                  data_d = shift_q;
                  if (ptr_q == PTR_LAST) begin
                     done_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Leaving load mode restarts the load from address 0 and drops any pending strobe.
      if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         armed_d = 1'b0;
         ptr_d   = '0;
         done_d  = 1'b0;
         wr_d    = 1'b0;
         ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         armed_q <= 1'b0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         armed_q <= armed_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign mem_wr_en = wr_q;
   assign mem_addr  = ptr_q;
   assign mem_data  = data_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_loader.sv
// Randomized bench for uart_rx_loader: frames are checked against a per-frame
// model of the load pointer, done flag, error pulses and write timing.
module tb_uart_rx_loader;

   localparam int CPB        = 8;
   localparam int ADDR_W     = 8;
   localparam int LOAD_BYTES = 4;
   localparam int HALF       = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN     = 1'b1;
   localparam int FRAME_BITS = 10;
`else
   localparam bit PAR_EN     = 1'b0;
   localparam int FRAME_BITS = 9;
`endif
   // rx driven after edge N reaches the FSM two edges later; write follows the stop sample.
   localparam int WR_LAT = 3 + HALF + FRAME_BITS * CPB;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              rx;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              busy;
   logic              done;
   logic              frame_err;
   logic              parity_err;

   uart_rx_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (ADDR_W),
      .LOAD_BYTES  (LOAD_BYTES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rx        (rx),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy),
      .done      (done),
      .frame_err (frame_err),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Observed activity
   logic [16:0] obs_q[$];
   int ferr_cnt = 0, perr_cnt = 0;
   int last_wr_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, busy_rises = 0;
   logic busy_prev = 1'b0;

   always @(negedge clk) begin
      if (mem_wr_en) begin
         obs_q.push_back({done, mem_addr, mem_data});
         last_wr_cyc <= cyc;
      end
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (busy && !busy_prev) begin
         busy_rise_cyc <= cyc;
         busy_rises    <= busy_rises + 1;
      end
      if (!busy && busy_prev) busy_fall_cyc <= cyc;
      busy_prev <= busy;
   end

   // Reference model: one update per complete frame
   logic [16:0] exp_q[$];
   int m_ptr = 0;
   bit m_done = 1'b0;
   int exp_ferr = 0, exp_perr = 0;

   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      if (m_done) return;
      if (!stop_ok) exp_ferr++;
      if (!par_ok)  exp_perr++;
      if (stop_ok && par_ok) begin
         exp_q.push_back({(m_ptr == LOAD_BYTES - 1), 8'(m_ptr), b});
         if (m_ptr == LOAD_BYTES - 1) m_done = 1'b1;
         else m_ptr++;
      end
   endtask

   task automatic model_restart();
      m_ptr  = 0;
      m_done = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit par_flip,
                             output int n0);
      n0 = cyc;
      hold(1'b0, CPB);
      for (int k = 0; k < 8; k++) hold(b[k], CPB);
      if (PAR_EN) hold((^b) ^ par_flip, CPB);
      hold(stop_bit, CPB);
      model_frame(b, stop_bit, !par_flip);
   endtask

   task automatic compare_writes(input string tag);
      chk({tag, " wr count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0)
         chk({tag, " wr {done,addr,data}"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
      obs_q.delete();
      exp_q.delete();
      chk({tag, " frame_err pulses"}, 32'(ferr_cnt), 32'(exp_ferr));
      chk({tag, " parity_err pulses"}, 32'(perr_cnt), 32'(exp_perr));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_restart();
      hold(1'b1, 4);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'(0));
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(0));
      chk({tag, " mem_data"}, 32'(mem_data), 32'(0));
      chk({tag, " busy"}, 32'(busy), 32'(0));
      chk({tag, " done"}, 32'(done), 32'(0));
      chk({tag, " frame_err"}, 32'(frame_err), 32'(0));
      chk({tag, " parity_err"}, 32'(parity_err), 32'(0));
   endtask

   initial begin
      int n0, r0;
      logic [7:0] b;
      rx = 1'b1;
      enable = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      do_reset();

      // Single good frame with latency and busy window
      send_frame(8'hA5, 1'b1, 1'b0, n0);
      hold(1'b1, 2 * CPB);
      compare_writes("a5");
      chk("a5 write cycle", 32'(last_wr_cyc), 32'(n0 + WR_LAT));
      chk("a5 busy rise", 32'(busy_rise_cyc), 32'(n0 + 3));
      chk("a5 busy fall", 32'(busy_fall_cyc), 32'(n0 + WR_LAT));
      chk("a5 busy after", 32'(busy), 32'(0));

      // Short glitch is a false start
      do_reset();
      n0 = cyc;
      hold(1'b0, 2);
      hold(1'b1, HALF + 2);
      chk("glitch busy", 32'(busy), 32'(0));
      chk("glitch busy fall", 32'(busy_fall_cyc), 32'(n0 + 3 + HALF));
      chk("glitch addr", 32'(mem_addr), 32'(0));
      hold(1'b1, CPB);
      compare_writes("glitch");

      // Bad stop bit, then a long low line must not restart reception
      do_reset();
      send_frame(8'h3C, 1'b0, 1'b0, n0);
      r0 = busy_rises;
      hold(1'b0, 20);
      hold(1'b1, 2 * CPB);
      chk("ferr no false start", 32'(busy_rises), 32'(r0));
      send_frame(8'h11, 1'b1, 1'b0, n0);
      hold(1'b1, 2 * CPB);
      compare_writes("ferr");

      // Fill to LOAD_BYTES, then restart via enable
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, n0);
         hold(1'b1, CPB);
      end
      hold(1'b1, CPB);
      compare_writes("load");
      chk("load done", 32'(done), 32'(1));
      chk("load addr held", 32'(mem_addr), 32'(LOAD_BYTES - 1));
      enable = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;
      model_restart();
      chk("enable drop done", 32'(done), 32'(0));
      chk("enable drop addr", 32'(mem_addr), 32'(0));
      hold(1'b1, 4);
      send_frame(8'h06, 1'b1, 1'b0, n0);
      hold(1'b1, 2 * CPB);
      compare_writes("reload");
      chk("reload done", 32'(done), 32'(0));

      // Reset in the middle of data bit 4
      do_reset();
      send_frame(8'h5A, 1'b1, 1'b0, n0);
      hold(1'b1, 2 * CPB);
      compare_writes("pre-abort");
      b = 8'hC3;
      hold(1'b0, CPB);
      for (int k = 0; k < 4; k++) hold(b[k], CPB);
      hold(b[4], HALF);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_outputs_zero("mid-frame reset");
      reset = 1'b0;
      model_restart();
      hold(1'b1, 3 * CPB);
      compare_writes("abort");
      send_frame(8'h7E, 1'b1, 1'b0, n0);
      hold(1'b1, 2 * CPB);
      compare_writes("after abort");

      if (PAR_EN) begin
         do_reset();
         send_frame(8'h01, 1'b1, 1'b1, n0);
         hold(1'b1, 2 * CPB);
         compare_writes("parity bad");
         send_frame(8'h01, 1'b1, 1'b0, n0);
         hold(1'b1, 2 * CPB);
         compare_writes("parity good");
      end

      // Random frames with occasional errors and load restarts
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bit stop_bit, pflip;
         b = 8'($urandom);
         stop_bit = ($urandom_range(0, 4) != 0);
         pflip = PAR_EN && ($urandom_range(0, 3) == 0);
         send_frame(b, stop_bit, pflip, n0);
         hold(1'b1, CPB + $urandom_range(0, CPB));
         if ($urandom_range(0, 4) == 0) begin
            enable = 1'b0;
            @(posedge clk);
            #1;
            enable = 1'b1;
            model_restart();
            hold(1'b1, 4);
         end
      end
      hold(1'b1, CPB);
      compare_writes("random");
      chk("random done", 32'(done), 32'(m_done));
      chk("random addr", 32'(mem_addr), 32'(m_ptr));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
